// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display stages.
package seg_pkg;

    // All segments off (active-low).
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low hex glyphs, bit6 = a ... bit0 = g.
    localparam logic [6:0] HEX7 [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_e;

endpackage

// File: rtl/hex7_dec.sv
// Nibble to active-low seven-segment glyph.
module hex7_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Pure table lookup.
    always_comb begin
        seg = HEX7[nib];
    end

endmodule

// File: rtl/lfsr_seg_scan.sv
// Byte history display: keeps the last DEPTH accepted bytes and scans them
// as hex digits over 2*DEPTH multiplexed digits, with one dark cycle per slot.
module lfsr_seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 ret,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    input  logic                 hold,
    output logic [6:0]           seg,
    output logic [2*DEPTH-1:0]   an,
    output logic                 dp
);

    localparam int unsigned NDIG  = 2 * DEPTH;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   pre_q, pre_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         hist_q [DEPTH];
    logic [7:0]         hist_d [DEPTH];
    logic [6:0]         seg_d;
    logic [NDIG-1:0]    an_d;
    logic               dp_d;

    logic               accept;
    logic [3:0]         nib_arr [NDIG];
    logic [3:0]         cur_nib;
    logic [6:0]         cur_glyph;
    logic               digit_ok;

    assign in_ready = ret & ~hold;
    assign accept   = in_valid & in_ready;

    // History shift and fill count; oldest byte falls off the end.
    always_comb begin
        hist_d = hist_q;
        cnt_d  = cnt_q;
        if (accept) begin
            hist_d[0] = in_data;
            for (int i = 1; i < DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Scan FSM: BLANK is the pre == 0 cycle of every slot.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                pre_d = '0;
                idx_d = '0;
                if (accept) begin
                    state_d = BLANK;
                end
            end
            BLANK: begin
                pre_d   = pre_q + DIV_W'(1);
                state_d = SHOW;
            end
            SHOW: begin
                pre_d = pre_q + DIV_W'(1);
                if (pre_d == '0) begin
                    state_d = BLANK;
                    idx_d   = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Digits in scan order: even digit = low nibble, odd digit = high nibble.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nib_arr[2*i]   = hist_d[i][3:0];
            nib_arr[2*i+1] = hist_d[i][7:4];
        end
    end

    assign cur_nib  = nib_arr[idx_d];
    assign digit_ok = (int'(idx_d) / 2) < int'(cnt_d);

    hex7_dec u_hex7_dec (
        .nib (cur_nib),
        .seg (cur_glyph)
    );

    // Output values computed from next state so the flops track state in-cycle.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = '1;
        dp_d  = 1'b1;
        if (state_d == SHOW) begin
            seg_d = cur_glyph;
            if (digit_ok) begin
                an_d = ~({{(NDIG-1){1'b0}}, 1'b1} << idx_d);
            end
            dp_d = ~((idx_d == '0) & hold);
        end
    end

    // State, history and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!ret) begin
            state_q <= IDLE;
            pre_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            seg     <= SEG_OFF;
            an      <= '1;
            dp      <= 1'b1;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hist_q  <= hist_d;
            seg     <= seg_d;
            an      <= an_d;
            dp      <= dp_d;
        end
    end

endmodule

// File: tb/tb_lfsr_seg_scan.sv
// Bench for lfsr_seg_scan with DIV_W = 2, DEPTH = 4 (4-cycle slots, 8 digits).
module tb_lfsr_seg_scan;

    logic       clk = 1'b0;
    logic       ret;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       hold;
    logic [6:0] seg;
    logic [7:0] an;
    logic       dp;

    always #5 clk = ~clk;

    lfsr_seg_scan #(
        .DIV_W (2),
        .DEPTH (4)
    ) u_dut (
        .clk      (clk),
        .ret      (ret),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .hold     (hold),
        .seg      (seg),
        .an       (an),
        .dp       (dp)
    );

    int checks   = 0;
    int failures = 0;

    logic [6:0] hex_ref [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct packed {
        logic [6:0] seg;
        logic [7:0] an;
        logic       dp;
    } out_t;

    out_t sb [$];

    // Reference model: time since activation gives slot and phase directly.
    int         m_cnt;
    logic [7:0] m_hist [4];
    bit         m_active;
    int         m_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance the model across the coming edge and queue the expected outputs.
    task automatic model_step();
        out_t e;
        int   slot, phase, k;
        logic [3:0] nib;
        e.seg = 7'b1111111;
        e.an  = 8'hFF;
        e.dp  = 1'b1;
        if (!ret) begin
            m_cnt    = 0;
            m_active = 0;
            m_t      = 0;
            for (int i = 0; i < 4; i++) m_hist[i] = 8'h00;
        end else begin
            if (m_active) m_t = m_t + 1;
            if (in_valid && !hold) begin
                for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = in_data;
                if (m_cnt < 4) m_cnt = m_cnt + 1;
                if (!m_active) begin
                    m_active = 1;
                    m_t      = 0;
                end
            end
            if (m_active) begin
                phase = m_t % 4;
                slot  = (m_t / 4) % 8;
                if (phase != 0) begin
                    k     = slot / 2;
                    nib   = (slot % 2 == 1) ? m_hist[k][7:4] : m_hist[k][3:0];
                    e.seg = hex_ref[nib];
                    if (k < m_cnt) e.an = ~(8'h01 << slot);
                    e.dp  = (slot == 0 && hold) ? 1'b0 : 1'b1;
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic step();
        out_t e;
        model_step();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("seg", 32'(seg), 32'(e.seg));
            check("an", 32'(an), 32'(e.an));
            check("dp", 32'(dp), 32'(e.dp));
        end
        check("in_ready", 32'(in_ready), 32'(ret & ~hold));
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    int  dp_low;
    bit  found;

    initial begin
        ret      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        hold     = 1'b0;

        // Reset
        repeat (3) step();
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hFF);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_ready", 32'(in_ready), 32'd0);
        ret = 1'b1;
        #1;
        check("rel_ready", 32'(in_ready), 32'd1);
        repeat (5) step();
        check("idle_an", 32'(an), 32'hFF);

        // Single byte
        push(8'hA5);
        check("a5_blank_an", 32'(an), 32'hFF);
        check("a5_blank_seg", 32'(seg), 32'h7F);
        step();
        check("a5_d0_an", 32'(an), 32'hFE);
        check("a5_d0_seg", 32'(seg), 32'(7'b0100100));
        repeat (3) step();
        check("a5_gap_an", 32'(an), 32'hFF);
        step();
        check("a5_d1_an", 32'(an), 32'hFD);
        check("a5_d1_seg", 32'(seg), 32'(7'b0001000));
        repeat (40) step();

        // Saturation, pushed back to back
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (40) step();

        // Hold refuses input while scanning continues
        hold     = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        dp_low   = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dp === 1'b0) dp_low++;
        end
        check("hold_dp_seen", 32'(dp_low > 0), 32'd1);
        hold     = 1'b0;
        in_valid = 1'b0;
        push(8'h3C);
        repeat (40) step();

        // Mid-scan reset during slot 3 SHOW
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_active && ((m_t / 4) % 8) == 3 && (m_t % 4) == 2) found = 1;
            else step();
        end
        check("slot3_found", 32'(found), 32'd1);
        ret = 1'b0;
        step();
        check("mrst_seg", 32'(seg), 32'h7F);
        check("mrst_an", 32'(an), 32'hFF);
        check("mrst_dp", 32'(dp), 32'd1);
        ret = 1'b1;
        repeat (5) step();
        check("mrst_idle_an", 32'(an), 32'hFF);
        push(8'h77);
        step();
        check("restart_an", 32'(an), 32'hFE);
        check("restart_seg", 32'(seg), 32'(7'b0001111));
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_seg_scan.md
# lfsr_seg_scan

Downstream display stage for the 8-bit LFSR generator. It accepts each new byte over a valid/ready handshake and keeps a rolling history of the last DEPTH bytes. It time-multiplexes that history onto a 2·DEPTH-digit common-anode seven-segment display as hex digits, with a one-cycle ghost-blanking gap between digit slots.

## Interface
Parameters:
- DIV_W, default 16: prescaler width; one digit slot lasts 2^DIV_W cycles.
- DEPTH, default 4: number of bytes held; the display has 2·DEPTH digits.

Ports:
- clk  in  1  sole clock, rising edge.
- ret  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  LFSR byte.
- in_ready  out  1  `ret & ~hold`, combinational; 0 while in reset.
- hold  in  1  freeze: refuse input and keep the current history.
- seg  out  7  active-low segments; bit6 = a … bit0 = g.
- an  out  2·DEPTH  active-low digit enables.
- dp  out  1  active-low decimal point.

## Operation
- Accept on any edge where in_valid & in_ready.
  - Shift the history: hist[0] ← in_data, hist[i] ← hist[i-1].
  - cnt ← min(cnt+1, DEPTH). The oldest entry is dropped silently.
- Digit mapping:
  - digit 2k shows hist[k][3:0].
  - digit 2k+1 shows hist[k][7:4].
  - A digit with k ≥ cnt is dark (an bit = 1), but its time slot is still spent.
- Hex code for segments 0–F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- FSM states:
  - IDLE: after reset and while cnt = 0. pre and idx are held at 0. All outputs dark.
  - BLANK: the cycle with pre = 0 in a non-IDLE state. an is all 1, seg = 1111111.
  - SHOW: pre ≠ 0. an[idx] = 0 if that digit is valid, and seg = hex code of its nibble.
- Transitions:
  - IDLE → BLANK on the first accept, with idx = 0 and pre = 0.
  - BLANK → SHOW on the next cycle.
  - SHOW → BLANK when pre wraps from 2^DIV_W−1 to 0. On the same edge idx ← idx+1, wrapping 2·DEPTH−1 → 0.
- pre counts +1 every cycle outside IDLE. The counter is DIV_W bits and wraps naturally.
- dp = 0 only in SHOW with idx = 0 and hold = 1, as a freeze indicator. Otherwise dp = 1.
- Accept during SHOW: the shown nibble changes on the next cycle. idx and pre are not disturbed.
- hold = 1 with in_valid = 1: no accept and no shift. Scanning continues.

## Timing
- seg, an and dp are flops. They are loaded from next-state values, so in any cycle they match state, idx and hist of that same cycle.
- Reset values (ret = 0 at an edge), effective the cycle after that edge:
  - seg = 1111111, an = all 1, dp = 1.
  - cnt = 0, idx = 0, pre = 0, state IDLE, hist = 0.
  - Reset mid-SHOW aborts the scan immediately.
- Latency:
  - A byte accepted at edge N is in hist[0] from cycle N+1.
  - The first byte after IDLE is first lit at cycle N+2 (BLANK at N+1).
- Slot length is exactly 2^DIV_W cycles: 1 BLANK + (2^DIV_W−1) SHOW.
- A full scan is 2·DEPTH·2^DIV_W cycles.

## Structure
- Shared package seg_pkg holds:
  - the 16-entry HEX7 constant array.
  - SEG_OFF = 7'b1111111.
  - the state enum (IDLE, BLANK, SHOW).
- Sub-module hex7_dec: combinational nibble → 7-bit active-low code. The LFSR display stage reuses it.
- Top level contains: history shift register, cnt, pre, idx, FSM, output flops.

## Test plan
Bench runs DIV_W = 2, DEPTH = 4.
- **Reset:** hold ret = 0 for 3 cycles → seg = 1111111, an = 11111111, dp = 1, in_ready = 0. After release, in_ready = 1 and outputs stay dark with no input.
- **Single byte:** push 0xA5 → 1 BLANK cycle, then 3 cycles an = 11111110 with seg = 0100100, then BLANK, then 3 cycles an = 11111101 with seg = 0001000. Slots 2–7: an = 11111111.
- **Saturation:** push 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back → cnt = 4.
  - Slot 6 shows seg = 0010010 (0x02 low nibble).
  - Slot 0 shows 0100100.
  - 0x01 is gone.
- **Hold:** hold = 1 with in_valid = 1 and in_data = 0xFF for 40 cycles → in_ready = 0, history unchanged. In slot 0 SHOW, dp = 0. Release hold → accept resumes.
- **Wrap:** observe slot 7 → BLANK → slot 0. There is exactly one all-dark cycle between the two, and idx returns to 0.
- **Mid-scan reset:** ret = 0 for 1 cycle during slot 3 SHOW → next cycle all outputs at reset values, state IDLE. The next push restarts at slot 0.
